// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Trap/return sequencer upstream of the machine-mode CSR block. Watches the
//   commit stage for exceptions, mret and a synchronized external interrupt,
//   drives the CSR trap-update handshake, then flushes the pipeline and
//   redirects fetch to mtvec (trap) or mepc (return). Stalls the core while a
//   trap or return is in flight.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   commit_*        retiring-instruction info (valid, pc, exc, cause, mret)
//   ext_irq         raw asynchronous external interrupt
//   irq_enable      mstatus.MIE
//   mtvec, mepc     trap handler / saved return PC from the CSR block
//   trap_valid      trap update request (held until trap_ack)
//   trap_cause      {interrupt, code}
//   trap_pc         PC to save into MEPC
//   trap_ack        CSR block accepted the trap update
//   ret_valid       one-cycle MSTATUS restore on mret
//   pending_irq     synchronized, masked interrupt
//   stall, flush    high whenever the sequencer is not idle
//   redirect_valid  one-cycle fetch redirect
//   redirect_pc     fetch redirect target
module trap_sequencer #(
   parameter logic [4:0] IRQ_CAUSE = 5'd11
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        commit_exc,
   input  logic [4:0]  commit_cause,
   input  logic        commit_mret,
   input  logic        ext_irq,
   input  logic        irq_enable,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        trap_valid,
   output logic [5:0]  trap_cause,
   output logic [31:0] trap_pc,
   input  logic        trap_ack,
   output logic        ret_valid,
   output logic        pending_irq,
   output logic        stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      REDIRECT
   } state_t;

   state_t state;
   logic   irq_s1;
   logic   irq_s2;

   assign pending_irq = irq_s2 & irq_enable;

   // Output registers double as the latched cause/pc/target and return flag:
   // trap_cause/trap_pc hold the latched trap, redirect_pc the latched target
   // and ret_valid the return flag, each cleared whenever it is not driven.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         irq_s1         <= 1'b0;
         irq_s2         <= 1'b0;
         trap_valid     <= 1'b0;
         trap_cause     <= '0;
         trap_pc        <= '0;
         ret_valid      <= 1'b0;
         stall          <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         irq_s1 <= ext_irq;
         irq_s2 <= irq_s1;

         unique case (state)
            IDLE: begin
               if (commit_valid) begin
                  if (commit_exc) begin
                     state      <= REQ;
                     trap_valid <= 1'b1;
                     trap_cause <= {1'b0, commit_cause};
                     trap_pc    <= commit_pc;
                     stall      <= 1'b1;
                     flush      <= 1'b1;
                  end else if (pending_irq) begin
                     // Retiring instruction is squashed; its PC is the
                     // resume point.
                     state      <= REQ;
                     trap_valid <= 1'b1;
                     trap_cause <= {1'b1, IRQ_CAUSE};
                     trap_pc    <= commit_pc;
                     stall      <= 1'b1;
                     flush      <= 1'b1;
                  end else if (commit_mret) begin
                     state          <= REDIRECT;
                     redirect_valid <= 1'b1;
                     redirect_pc    <= mepc;
                     ret_valid      <= 1'b1;
                     stall          <= 1'b1;
                     flush          <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (trap_ack) begin
                  state          <= REDIRECT;
                  trap_valid     <= 1'b0;
                  trap_cause     <= '0;
                  trap_pc        <= '0;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= mtvec;
                  ret_valid      <= 1'b0;
               end
            end

            REDIRECT: begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               redirect_pc    <= '0;
               ret_valid      <= 1'b0;
               stall          <= 1'b0;
               flush          <= 1'b0;
            end

            default: begin
               state          <= IDLE;
               trap_valid     <= 1'b0;
               trap_cause     <= '0;
               trap_pc        <= '0;
               redirect_valid <= 1'b0;
               redirect_pc    <= '0;
               ret_valid      <= 1'b0;
               stall          <= 1'b0;
               flush          <= 1'b0;
            end
         endcase
      end
   end

endmodule
